// File: rtl/cla_serial_subtractor_if.sv
// Command/result handshake bundle for cla_serial_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start_valid, a, b, bin, res_ready,
    input  start_ready, res_valid, diff, bout, busy
`ifdef SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start_valid, a, b, bin, res_ready,
    output start_ready, res_valid, diff, bout, busy
`ifdef SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin over WIDTH/4 cycles using a 4-bit CLA per nibble.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module cla_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [KW-1:0]    r_k;
  logic             r_borrow;
  logic             r_bout;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_busy;
`ifdef SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  // Operands shift right each BUSY cycle, so the active nibble is always bits [3:0].
  logic [3:0] w_a_nib;
  logic [3:0] w_nb_nib;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;
  logic [3:0] w_sum;

  assign w_a_nib  = r_a[3:0];
  assign w_nb_nib = ~r_b[3:0];
  assign w_g      = w_a_nib & w_nb_nib;
  assign w_p      = w_a_nib ^ w_nb_nib;

  // Carry-in is the inverted borrow; every carry is a flat look-ahead term.
  assign w_c[0] = ~r_borrow;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_sum  = w_p ^ w_c[3:0];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_diff        <= '0;
      r_k           <= '0;
      r_borrow      <= 1'b0;
      r_bout        <= 1'b0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
`ifdef SUB_OVF_EN
      r_a_msb       <= 1'b0;
      r_b_msb       <= 1'b0;
      r_ovf         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_a           <= bus.a;
            r_b           <= bus.b;
            r_borrow      <= bus.bin;
            r_k           <= '0;
            r_state       <= S_BUSY;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
`ifdef SUB_OVF_EN
            r_a_msb       <= bus.a[WIDTH-1];
            r_b_msb       <= bus.b[WIDTH-1];
`endif
          end
        end
        S_BUSY: begin
          r_a      <= r_a >> 4;
          r_b      <= r_b >> 4;
          // New nibble enters at the top; after N cycles it has walked to its own slot.
          r_diff   <= (r_diff >> 4) | (WIDTH'(w_sum) << (WIDTH - 4));
          r_borrow <= ~w_c[4];
          r_k      <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_bout      <= ~w_c[4];
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
`ifdef SUB_OVF_EN
            r_ovf       <= (r_a_msb ^ r_b_msb) & (w_sum[3] ^ r_a_msb);
`endif
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_state       <= S_IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_res_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.busy        = r_busy;
  assign bus.diff        = r_diff;
  assign bus.bout        = r_bout;
`ifdef SUB_OVF_EN
  assign bus.ovf         = r_ovf;
`endif
endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Directed bench for cla_serial_subtractor (WIDTH=16): vector table plus reset and backpressure sequences.
module tb_cla_serial_subtractor;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cla_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  cla_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called #1 after the accept edge: waits for DONE, checks the result, then completes the handshake.
  task automatic wait_result(input string name, input logic [15:0] exp_diff,
                             input logic exp_bout, input logic exp_ovf);
    int n;
    n = 0;
    bus.start_valid = 1'b0;
    check({name, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    check({name, " ready_low_busy"}, 32'(bus.start_ready), 32'd0);
    while (!bus.res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'd4);
    check({name, " diff"}, 32'(bus.diff), 32'(exp_diff));
    check({name, " bout"}, 32'(bus.bout), 32'(exp_bout));
    check({name, " busy_done"}, 32'(bus.busy), 32'd1);
`ifdef SUB_OVF_EN
    check({name, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x in ovf table entry");
`endif
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({name, " valid_dropped"}, 32'(bus.res_valid), 32'd0);
    check({name, " idle_ready"}, 32'(bus.start_ready), 32'd1);
    check({name, " diff_kept"}, 32'(bus.diff), 32'(exp_diff));
  endtask

  task automatic run_op(input string name, input vec_t v);
    bus.a           = v.a;
    bus.b           = v.b;
    bus.bin         = v.bin;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    wait_result(name, v.exp_diff, v.exp_bout, v.exp_ovf);
  endtask

  vec_t vecs [9];

  initial begin
    bit seen;
    n_checks = 0;
    n_pass   = 0;
    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[8] = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1, 1'b0};

    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.bin         = 1'b0;
    rst             = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst start_ready", 32'(bus.start_ready), 32'd1);
    check("rst res_valid", 32'(bus.res_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst diff", 32'(bus.diff), 32'd0);
    check("rst bout", 32'(bus.bout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // a==b without borrow-in: zero, no borrow.
    run_op("equal", '{16'h4C4C, 16'h4C4C, 1'b0, 16'h0000, 1'b0, 1'b0});

    // Backpressure: result held while a new command waits at the input.
    bus.a = 16'h1000; bus.b = 16'h0001; bus.bin = 1'b0; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    check("bp valid", 32'(bus.res_valid), 32'd1);
    bus.a = 16'h0003; bus.b = 16'h0005; bus.bin = 1'b0; bus.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold_diff%0d", i), 32'(bus.diff), 32'h0FFF);
      check($sformatf("bp hold_bout%0d", i), 32'(bus.bout), 32'd0);
      check($sformatf("bp hold_valid%0d", i), 32'(bus.res_valid), 32'd1);
      check($sformatf("bp no_ready%0d", i), 32'(bus.start_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("bp idle_ready", 32'(bus.start_ready), 32'd1);
    check("bp idle_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    wait_result("bp pending", 16'hFFFE, 1'b1, 1'b0);

    // Reset during the second BUSY cycle aborts the command.
    bus.a = 16'h00F0; bus.b = 16'h0010; bus.bin = 1'b0; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst start_ready", 32'(bus.start_ready), 32'd1);
    check("midrst res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst diff", 32'(bus.diff), 32'd0);
    check("midrst bout", 32'(bus.bout), 32'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    check("midrst no_result", 32'(seen), 32'd0);
    run_op("after_rst", '{16'h00A0, 16'h0050, 1'b0, 16'h0050, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
